// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master.
//   spi_state_e      : transfer sequencer states
//   SPI_MODE0..3     : mode encodings as {cpol, cpha}
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period timebase.
// Counts CLK_DIV system clocks while enabled and raises tick for one cycle
// at the end of each half-period.
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   clr   : restart the half-period from zero (transfer accepted)
//   en    : count enable (transfer in progress)
//   tick  : one-cycle pulse marking the end of a half-period
module spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_s;

    assign wrap_s = (cnt_q == CNT_MAX);
    assign tick   = en & wrap_s;

    // Next half-period count: restart, advance/wrap, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en) begin
            cnt_d = wrap_s ? {CW{1'b0}} : (cnt_q + CW'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Half-period counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: DATA_W-bit words MSB first, SCLK half-period of
// CLK_DIV clocks, any of the four SPI modes chosen per transfer, NUM_SS
// active-low selects, busy/done handshake.
//   clk, rst_n   : system clock, synchronous active-low reset
//   start        : transfer request, only honoured in IDLE
//   data_out     : word to send
//   ss_sel       : slave index (out-of-range index keeps all selects high)
//   cpol, cpha   : mode for this transfer, latched at start
//   busy, done   : in-progress flag and end-of-transfer pulse
//   data_in      : received word, updated with done
//   SCLK, MOSI   : serial clock and data out
//   MISO         : serial data in
//   SS           : active-low slave selects
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_SS  = 1,
    localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_out,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_in,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS
);

    localparam int            EW        = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [NUM_SS-1:0] ss_q, ss_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpha_q, cpha_d;

    logic              accept_s;
    logic              tick_s;
    logic [EW-1:0]     edge_nxt_s;
    logic              odd_s;
    logic              last_s;
    logic              sample_s;
    logic              shift_s;

    // Active-low one-hot select; an index beyond NUM_SS selects nobody
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = {NUM_SS{1'b1}};
        for (int i = 0; i < NUM_SS; i++) begin
            v[i] = (int'(sel) == i) ? 1'b0 : 1'b1;
        end
        return v;
    endfunction

    assign accept_s = (state_q == ST_IDLE) & start;

    spi_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept_s),
        .en   (state_q != ST_IDLE),
        .tick (tick_s)
    );

    // The tick that ends SETUP already produces SCLK edge 1, so the edge
    // number is always edge_q + 1 while SETUP/XFER tick.
    assign edge_nxt_s = edge_q + EW'(1);
    assign odd_s      = edge_nxt_s[0];
    assign last_s     = (edge_nxt_s == EDGE_LAST);
    // cpha=0: sample on leading (odd) edges, drive on trailing except the last.
    // cpha=1: drive on leading edges, sample on trailing edges.
    assign sample_s   = cpha_q ? ~odd_s : odd_s;
    assign shift_s    = cpha_q ? odd_s : (~odd_s & ~last_s);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_d = tick_s ? ST_XFER : ST_SETUP;
            ST_XFER:  state_d = (tick_s && last_s) ? ST_HOLD : ST_XFER;
            ST_HOLD:  state_d = tick_s ? ST_IDLE : ST_HOLD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_in_d = data_in_q;
        ss_d      = ss_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cpha_d    = cpha_q;
        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                if (start) begin
                    // For cpha=0 the MSB goes straight onto MOSI, so the
                    // shift register starts one bit ahead.
                    tx_d   = cpha ? data_out : {data_out[DATA_W-2:0], 1'b0};
                    mosi_d = cpha ? 1'b0 : data_out[DATA_W-1];
                    rx_d   = {DATA_W{1'b0}};
                    ss_d   = ss_decode(ss_sel);
                    busy_d = 1'b1;
                    edge_d = {EW{1'b0}};
                    cpha_d = cpha;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SETUP, ST_XFER: begin
                if (tick_s) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt_s;
                    rx_d   = sample_s ? {rx_q[DATA_W-2:0], MISO} : rx_q;
                    tx_d   = shift_s ? {tx_q[DATA_W-2:0], 1'b0} : tx_q;
                    mosi_d = last_s ? 1'b0 : (shift_s ? tx_q[DATA_W-1] : mosi_q);
                end else begin
                    sclk_d = sclk_q;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    ss_d      = {NUM_SS{1'b1}};
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    data_in_d = rx_q;
                    edge_d    = {EW{1'b0}};
                end else begin
                    ss_d = ss_q;
                end
            end
            default: begin
                ss_d   = {NUM_SS{1'b1}};
                busy_d = 1'b0;
                mosi_d = 1'b0;
                edge_d = {EW{1'b0}};
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q      <= {DATA_W{1'b0}};
            rx_q      <= {DATA_W{1'b0}};
            data_in_q <= {DATA_W{1'b0}};
            ss_q      <= {NUM_SS{1'b1}};
            edge_q    <= {EW{1'b0}};
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpha_q    <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_in_q <= data_in_d;
            ss_q      <= ss_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cpha_q    <= cpha_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign data_in = data_in_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: a table of transfers on an 8-bit,
// CLK_DIV=2, 4-select instance (loopback or a mode-aware slave model), plus
// sequences for start-while-busy, reset mid-transfer, and a 16-bit CLK_DIV=1
// 5-select instance including an out-of-range select.
module tb_spi_master_cfg;
    import spi_pkg::*;

    localparam int DW_A = 8;
    localparam int CD_A = 2;
    localparam int NS_A = 4;
    localparam int DW_B = 16;
    localparam int CD_B = 1;
    localparam int NS_B = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start_a, cpol_a, cpha_a, busy_a, done_a, sclk_a, mosi_a, miso_a;
    logic [7:0]  dout_a, din_a;
    logic [1:0]  sel_a;
    logic [3:0]  ss_a;

    logic        start_b, cpol_b, cpha_b, busy_b, done_b, sclk_b, mosi_b, miso_b;
    logic [15:0] dout_b, din_b;
    logic [2:0]  sel_b;
    logic [4:0]  ss_b;

    spi_master_cfg #(.DATA_W(DW_A), .CLK_DIV(CD_A), .NUM_SS(NS_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_out(dout_a), .ss_sel(sel_a),
        .cpol(cpol_a), .cpha(cpha_a), .busy(busy_a), .done(done_a), .data_in(din_a),
        .SCLK(sclk_a), .MOSI(mosi_a), .MISO(miso_a), .SS(ss_a));

    spi_master_cfg #(.DATA_W(DW_B), .CLK_DIV(CD_B), .NUM_SS(NS_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_out(dout_b), .ss_sel(sel_b),
        .cpol(cpol_b), .cpha(cpha_b), .busy(busy_b), .done(done_b), .data_in(din_b),
        .SCLK(sclk_b), .MOSI(mosi_b), .MISO(miso_b), .SS(ss_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model for instance A: drives its word MSB first, on the edges
    // where a slave of the chosen mode launches data.
    logic       slave_en, slave_miso, slv_act, slv_cpha, slv_sclk_prev;
    logic [7:0] slave_word, slv_sr;
    int         slv_edges;

    assign miso_a = slave_en ? slave_miso : mosi_a;
    assign miso_b = mosi_b;

    always @(posedge clk) begin
        #2;
        if (busy_a && !slv_act) begin
            slv_act   = 1'b1;
            slv_cpha  = cpha_a;
            slv_edges = 0;
            if (cpha_a) begin
                slave_miso = 1'b0;
                slv_sr     = slave_word;
            end else begin
                slave_miso = slave_word[7];
                slv_sr     = {slave_word[6:0], 1'b0};
            end
        end else if (busy_a && slv_act && (sclk_a != slv_sclk_prev)) begin
            slv_edges++;
            if (slv_cpha ? ((slv_edges % 2) == 1) : (((slv_edges % 2) == 0) && (slv_edges < 2 * DW_A))) begin
                slave_miso = slv_sr[7];
                slv_sr     = {slv_sr[6:0], 1'b0};
            end
        end else if (!busy_a) begin
            slv_act = 1'b0;
        end
        slv_sclk_prev = sclk_a;
    end

    typedef struct {
        logic [1:0] mode;
        logic [1:0] sel;
        logic [7:0] dout;
        logic       loopback;
        logic [7:0] slave;
        logic [7:0] exp_data;
        logic [3:0] exp_ss;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[4];

    // One transfer on instance A. poke re-requests a transfer mid-way with
    // other data and polarity; rst_edge > 0 asserts reset once that many SCLK
    // edges have been seen.
    task automatic run_a(input vec_t v, input bit poke, input int rst_edge);
        int lat, edges, rises, ss_low, mosi_bad, extra;
        logic sp, mp, got_done, drive_lvl;
        exp_t e;
        @(negedge clk);
        cpol_a     = v.mode[1];
        cpha_a     = v.mode[0];
        sel_a      = v.sel;
        dout_a     = v.dout;
        slave_en   = ~v.loopback;
        slave_word = v.slave;
        drive_lvl  = v.mode[1] ^ v.mode[0];
        @(negedge clk);
        chk("idle_sclk", sclk_a, v.mode[1]);
        start_a = 1'b1;
        @(posedge clk);
        e.data = {8'h00, v.exp_data};
        e.lat  = (2 * DW_A + 1) * CD_A;
        sb.push_back(e);
        #1;
        start_a = 1'b0;
        chk("busy_after_start", busy_a, 1'b1);
        chk("ss_select", ss_a, v.exp_ss);
        sp = sclk_a; mp = mosi_a;
        lat = 0; edges = 0; rises = 0; mosi_bad = 0; got_done = 1'b0;
        ss_low = (ss_a != 4'hF) ? 1 : 0;
        while (!got_done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (sclk_a != sp) begin
                edges++;
                if (sclk_a) rises++;
            end
            if ((mosi_a != mp) && (edges < 2 * DW_A) && !((sclk_a != sp) && (sclk_a == drive_lvl)))
                mosi_bad++;
            if (ss_a != 4'hF) ss_low++;
            if (poke && lat == 10) begin
                start_a = 1'b1;
                dout_a  = ~v.dout;
                cpol_a  = ~v.mode[1];
            end
            if (poke && lat == 12) start_a = 1'b0;
            if (rst_edge > 0 && edges == rst_edge) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                chk("rst_ss", ss_a, 4'hF);
                chk("rst_sclk", sclk_a, 1'b0);
                chk("rst_busy", busy_a, 1'b0);
                chk("rst_data_in", din_a, 8'h00);
                chk("rst_done", done_a, 1'b0);
                rst_n = 1'b1;
                sb.delete();
                extra = 0;
                repeat (50) begin
                    @(posedge clk);
                    #1;
                    if (done_a || busy_a) extra++;
                end
                chk("no_done_after_reset", extra, 0);
                return;
            end
            if (done_a) got_done = 1'b1;
            sp = sclk_a; mp = mosi_a;
        end
        chk("done_seen", got_done, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("data_in", din_a, e.data[7:0]);
            chk("done_latency", lat, e.lat);
        end else begin
            chk("scoreboard_nonempty", sb.size(), 1);
        end
        chk("sclk_rises", rises, DW_A);
        chk("ss_low_cycles", ss_low, (v.exp_ss == 4'hF) ? 0 : (2 * DW_A + 1) * CD_A);
        chk("mosi_drive_edge", mosi_bad, 0);
        chk("busy_at_done", busy_a, 1'b0);
        chk("ss_release", ss_a, 4'hF);
        if (poke) begin
            extra = 0;
            repeat (50) begin
                @(posedge clk);
                #1;
                if (done_a || busy_a) extra++;
            end
            chk("no_second_xfer", extra, 0);
        end
    endtask

    // One loopback transfer on instance B
    task automatic run_b(input logic [1:0] mode, input logic [2:0] sel,
                         input logic [15:0] dout, input logic [4:0] exp_ss);
        int lat, ss_low;
        logic got_done;
        exp_t e;
        @(negedge clk);
        cpol_b = mode[1];
        cpha_b = mode[0];
        sel_b  = sel;
        dout_b = dout;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        e.data = dout;
        e.lat  = (2 * DW_B + 1) * CD_B;
        sb.push_back(e);
        #1;
        start_b = 1'b0;
        chk("b_busy_after_start", busy_b, 1'b1);
        chk("b_ss_select", ss_b, exp_ss);
        lat = 0; got_done = 1'b0;
        ss_low = (ss_b != 5'h1F) ? 1 : 0;
        while (!got_done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (ss_b != 5'h1F) ss_low++;
            if (done_b) got_done = 1'b1;
        end
        chk("b_done_seen", got_done, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("b_data_in", din_b, e.data);
            chk("b_done_latency", lat, e.lat);
        end else begin
            chk("b_scoreboard_nonempty", sb.size(), 1);
        end
        chk("b_ss_low_cycles", ss_low, (exp_ss == 5'h1F) ? 0 : (2 * DW_B + 1) * CD_B);
        chk("b_busy_at_done", busy_b, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode: SPI_MODE0, sel: 2'd0, dout: 8'hA5, loopback: 1'b1, slave: 8'h00, exp_data: 8'hA5, exp_ss: 4'b1110};
        vecs[1] = '{mode: SPI_MODE3, sel: 2'd1, dout: 8'h96, loopback: 1'b0, slave: 8'h3C, exp_data: 8'h3C, exp_ss: 4'b1101};
        vecs[2] = '{mode: SPI_MODE1, sel: 2'd2, dout: 8'h5A, loopback: 1'b0, slave: 8'hC3, exp_data: 8'hC3, exp_ss: 4'b1011};
        vecs[3] = '{mode: SPI_MODE2, sel: 2'd3, dout: 8'h0F, loopback: 1'b1, slave: 8'h00, exp_data: 8'h0F, exp_ss: 4'b0111};

        rst_n = 1'b0;
        start_a = 1'b0; cpol_a = 1'b0; cpha_a = 1'b0; dout_a = 8'h00; sel_a = 2'd0;
        start_b = 1'b0; cpol_b = 1'b0; cpha_b = 1'b0; dout_b = 16'h0000; sel_b = 3'd0;
        slave_en = 1'b0; slave_word = 8'h00; slave_miso = 1'b0;
        slv_act = 1'b0; slv_cpha = 1'b0; slv_sclk_prev = 1'b0; slv_sr = 8'h00; slv_edges = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ss_a", ss_a, 4'hF);
        chk("reset_sclk_a", sclk_a, 1'b0);
        chk("reset_mosi_a", mosi_a, 1'b0);
        chk("reset_busy_a", busy_a, 1'b0);
        chk("reset_done_a", done_a, 1'b0);
        chk("reset_data_in_a", din_a, 8'h00);
        chk("reset_ss_b", ss_b, 5'h1F);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_a(vecs[i], 1'b0, 0);
        end

        // start re-pulsed with new data and polarity while busy
        run_a(vecs[0], 1'b1, 0);
        // reset once five SCLK edges have gone out
        run_a(vecs[2], 1'b0, 5);
        // the block recovers cleanly after reset
        run_a(vecs[1], 1'b0, 0);

        run_b(SPI_MODE1, 3'd1, 16'hBEEF, 5'b11101);
        run_b(SPI_MODE2, 3'd5, 16'h1234, 5'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
